// File: rtl/led_pkg.sv
// Shared definitions for the key/mode controller and the downstream LED FSM.
package led_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_DB_PRESS   = 2'd1,
        ST_HELD       = 2'd2,
        ST_DB_RELEASE = 2'd3
    } key_state_t;

    // Counter width able to hold values up to max(a, b) - 1, never narrower than 1 bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/key_mode_ctrl_if.sv
// Key input and pulse/mode outputs of the key controller.
interface key_mode_ctrl_if;
    import led_pkg::*;

    logic              key_n;
    logic              key_press;
    logic              key_long;
    logic              key_level;
    logic [MODE_W-1:0] mode;

    modport master (
        output key_n,
        input  key_press,
        input  key_long,
        input  key_level,
        input  mode
    );

    modport slave (
        input  key_n,
        output key_press,
        output key_long,
        output key_level,
        output mode
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input, reusable for any key.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the raw input through two flops; reset to the idle (released) level.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_mode_ctrl.sv
// Push-button debouncer with short/long press detection and a 2-bit mode counter.
//
// state         | meaning
// --------------+-----------------------------------------------------------
// ST_IDLE       | key released and debounced
// ST_DB_PRESS   | key seen low, waiting for it to stay low DEBOUNCE_CYCLES
// ST_HELD       | press accepted, timing towards a long press
// ST_DB_RELEASE | key seen high, waiting for it to stay high DEBOUNCE_CYCLES
module key_mode_ctrl
    import led_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int LONG_CYCLES     = 50_000_000
) (
    input  logic            clk,
    input  logic            rst,
    key_mode_ctrl_if.slave  kif
);

    localparam int               CNT_W     = cnt_width(DEBOUNCE_CYCLES, LONG_CYCLES);
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

    logic              key_sync;
    key_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              long_done_q, long_done_d;
    logic              press_q, press_d;
    logic              long_q, long_d;
    logic              level_q, level_d;
    logic [MODE_W-1:0] mode_q, mode_d;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (kif.key_n),
        .q   (key_sync)
    );

    // Next-state, shared counter, pulse and mode computation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        long_done_d = long_done_q;
        press_d     = 1'b0;
        long_d      = 1'b0;
        mode_d      = mode_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!key_sync) begin
                    state_d = ST_DB_PRESS;
                end
            end
            ST_DB_PRESS: begin
                if (key_sync) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                    press_d = 1'b1;
                    mode_d  = mode_q + MODE_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HELD: begin
                if (key_sync) begin
                    state_d = ST_DB_RELEASE;
                    cnt_d   = '0;
                end else if (cnt_q == LONG_LAST) begin
                    // Counter parks at the terminal value; long_done blocks repeats.
                    if (!long_done_q) begin
                        long_d      = 1'b1;
                        long_done_d = 1'b1;
                        mode_d      = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DB_RELEASE: begin
                if (!key_sync) begin
                    // Release bounce: back to held without a new press pulse.
                    state_d = ST_HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d     = ST_IDLE;
                    cnt_d       = '0;
                    long_done_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        level_d = (state_d == ST_HELD) || (state_d == ST_DB_RELEASE);
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            long_done_q <= 1'b0;
            press_q     <= 1'b0;
            long_q      <= 1'b0;
            level_q     <= 1'b0;
            mode_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            long_done_q <= long_done_d;
            press_q     <= press_d;
            long_q      <= long_d;
            level_q     <= level_d;
            mode_q      <= mode_d;
        end
    end

    assign kif.key_press = press_q;
    assign kif.key_long  = long_q;
    assign kif.key_level = level_q;
    assign kif.mode      = mode_q;

endmodule

// File: tb/tb_key_mode_ctrl.sv
// Self-checking bench for key_mode_ctrl with short debounce/long timings.
module tb_key_mode_ctrl;
    import led_pkg::*;

    localparam int DB = 5;
    localparam int LG = 20;

    logic clk = 1'b0;
    logic rst;
    always #10 clk = ~clk;

    key_mode_ctrl_if kif ();

    key_mode_ctrl #(
        .DEBOUNCE_CYCLES (DB),
        .LONG_CYCLES     (LG)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kif (kif.slave)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: run-length view of the synchronized key.
    bit m_s1, m_s2, m_level, m_press, m_long, m_long_done;
    int m_run, m_zrun, m_mode;

    // Sequence bookkeeping.
    int n_press, n_long, n_level, press_cyc, long_cyc, press_mode, long_mode;
    int modes_seen[$];

    typedef struct {
        logic rst;
        logic key_n;
        logic e_press;
        logic e_long;
        logic e_level;
        int   e_mode;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_edge(input bit r, input bit kn);
        bit ks, smp, flipped;
        if (r) begin
            m_s1 = 1; m_s2 = 1; m_level = 0; m_press = 0; m_long = 0;
            m_long_done = 0; m_run = 0; m_zrun = 0; m_mode = 0;
            return;
        end
        ks   = m_s2;
        m_s2 = m_s1;
        m_s1 = kn;
        m_press = 0;
        m_long  = 0;
        flipped = 0;
        smp = !ks;
        if (smp != m_level) begin
            m_run++;
            if (m_run == DB + 1) begin
                m_level = smp;
                m_run   = 0;
                flipped = 1;
                if (m_level) begin
                    m_press = 1;
                    m_mode  = (m_mode + 1) % 4;
                    m_zrun  = 0;
                end else begin
                    m_long_done = 0;
                end
            end
        end else begin
            m_run = 0;
        end
        if (m_level && !flipped) begin
            if (!ks) begin
                m_zrun++;
                if (m_zrun == LG && !m_long_done) begin
                    m_long      = 1;
                    m_long_done = 1;
                    m_mode      = 0;
                end
            end else begin
                m_zrun = -1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(rst, kif.key_n);
        cyc++;
        @(negedge clk);
        check("press", kif.key_press, m_press);
        check("long",  kif.key_long,  m_long);
        check("level", kif.key_level, m_level);
        check("mode",  kif.mode,      m_mode);
        check("excl",  kif.key_press & kif.key_long, 1'b0);
    endtask

    task automatic clear_counts();
        n_press = 0; n_long = 0; n_level = 0;
        press_cyc = -1; long_cyc = -1; press_mode = -1; long_mode = -1;
        modes_seen.delete();
    endtask

    task automatic run_key(input logic val, input int n);
        for (int i = 0; i < n; i++) begin
            rst = 1'b0;
            kif.key_n = val;
            step();
            if (kif.key_press === 1'b1) begin
                n_press++; press_cyc = cyc; press_mode = kif.mode;
                modes_seen.push_back(int'(kif.mode));
            end
            if (kif.key_long === 1'b1) begin
                n_long++; long_cyc = cyc; long_mode = kif.mode;
            end
            if (kif.key_level === 1'b1) n_level++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        kif.key_n = 1'b1;
        for (int i = 0; i < 3; i++) step();
        rst = 1'b0;
    endtask

    initial begin
        int start, len;
        logic lvl;
        rst = 1'b1;
        kif.key_n = 1'b1;

        // Reset then a clean 12-cycle press; edges counted from the first low sample.
        for (int i = 0; i < 3; i++)
            tbl.push_back('{rst: 1'b1, key_n: 1'b1, e_press: 1'b0, e_long: 1'b0, e_level: 1'b0, e_mode: 0});
        for (int e = 1; e <= 22; e++)
            tbl.push_back('{rst: 1'b0, key_n: (e <= 12) ? 1'b0 : 1'b1,
                            e_press: (e == 8), e_long: 1'b0,
                            e_level: (e >= 8 && e <= 19),
                            e_mode: (e >= 8) ? 1 : 0});

        foreach (tbl[i]) begin
            rst = tbl[i].rst;
            kif.key_n = tbl[i].key_n;
            step();
            check("tbl_press", kif.key_press, tbl[i].e_press);
            check("tbl_long",  kif.key_long,  tbl[i].e_long);
            check("tbl_level", kif.key_level, tbl[i].e_level);
            check("tbl_mode",  kif.mode,      tbl[i].e_mode);
        end

        // Bounce: too short on both low runs.
        clear_counts();
        run_key(1'b0, 3); run_key(1'b1, 2); run_key(1'b0, 3); run_key(1'b1, 12);
        check("bounce_press", n_press, 0);
        check("bounce_level", n_level, 0);
        check("bounce_mode",  kif.mode, 1);

        // Four clean presses from reset: mode 1,2,3,0.
        do_reset();
        clear_counts();
        for (int k = 0; k < 4; k++) begin
            run_key(1'b0, 12);
            run_key(1'b1, 12);
        end
        check("four_count", n_press, 4);
        for (int k = 0; k < 4; k++)
            check("four_mode", (k < modes_seen.size()) ? modes_seen[k] : -1, (k + 1) % 4);

        // Long hold.
        do_reset();
        clear_counts();
        start = cyc;
        run_key(1'b0, 40);
        run_key(1'b1, 12);
        check("long_press_cnt", n_press, 1);
        check("long_cnt",       n_long, 1);
        check("long_latency",   press_cyc - start, 8);
        check("long_delay",     long_cyc - press_cyc, LG);
        check("long_mode_p",    press_mode, 1);
        check("long_mode_l",    long_mode, 0);

        // Reset while held, key still low.
        do_reset();
        clear_counts();
        run_key(1'b0, 12);
        check("midrst_held", kif.key_level, 1'b1);
        rst = 1'b1;
        kif.key_n = 1'b0;
        step();
        check("midrst_press", kif.key_press, 1'b0);
        check("midrst_level", kif.key_level, 1'b0);
        check("midrst_mode",  kif.mode, 0);
        clear_counts();
        start = cyc;
        run_key(1'b0, 12);
        check("midrst_count",   n_press, 1);
        check("midrst_latency", press_cyc - start, 8);
        run_key(1'b1, 12);

        // Random run-length stimulus against the model.
        lvl = 1'b1;
        for (int r = 0; r < 250; r++) begin
            len = $urandom_range(1, (r % 5 == 0) ? 40 : 12);
            lvl = ~lvl;
            if ($urandom_range(0, 60) == 0) begin
                rst = 1'b1;
                kif.key_n = lvl;
                step();
            end
            run_key(lvl, len);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/key_mode_ctrl.md
KEY_MODE_CTRL -- requirements
Module: key_mode_ctrl

Interface
REQ-001 The module SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, meaning the stable-level cycles needed to accept a key edge (20 ms at 50 MHz).
REQ-002 The module SHALL have parameter LONG_CYCLES, default 50_000_000, meaning the held cycles after an accepted press that make it a long press (1 s at 50 MHz).
REQ-003 The module SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have port key_n, input, 1 bit: raw asynchronous push-button, low = pressed.
REQ-006 The module SHALL have port key_press, output, 1 bit: one-cycle pulse on each accepted press.
REQ-007 The module SHALL have port key_long, output, 1 bit: one-cycle pulse when a press has been held LONG_CYCLES.
REQ-008 The module SHALL have port key_level, output, 1 bit: debounced key state, 1 = pressed.
REQ-009 The module SHALL have port mode, output, 2 bits: LED pattern select fed to the downstream LED state machine.

Function
REQ-010 key_n SHALL pass through a 2-flop synchronizer; all logic below SHALL use only the synchronized value key_sync.
REQ-011 The FSM SHALL have states IDLE, DB_PRESS, HELD and DB_RELEASE, with one shared counter cnt of width clog2(max(DEBOUNCE_CYCLES, LONG_CYCLES)).
REQ-012 In IDLE, key_sync==0 SHALL move the FSM to DB_PRESS with cnt=0.
REQ-013 In DB_PRESS, key_sync==1 SHALL return the FSM to IDLE with cnt=0 (bounce rejected, no pulse).
REQ-014 In DB_PRESS, key_sync==0 with cnt<DEBOUNCE_CYCLES-1 SHALL increment cnt.
REQ-015 In DB_PRESS, key_sync==0 with cnt==DEBOUNCE_CYCLES-1 SHALL move the FSM to HELD with cnt=0, and SHALL register key_press=1 for exactly one cycle.
REQ-016 In HELD, cnt SHALL increment while key_sync==0 and cnt<LONG_CYCLES-1.
REQ-017 In HELD, when cnt reaches LONG_CYCLES-1, key_long SHALL be registered high for one cycle, and a sticky long_done flag SHALL prevent repeats until the next IDLE.
REQ-018 In HELD, key_sync==1 SHALL move the FSM to DB_RELEASE with cnt=0.
REQ-019 In DB_RELEASE, key_sync==0 SHALL return the FSM to HELD; cnt SHALL restart at 0 but long_done SHALL be kept, so there is no second key_press.
REQ-020 In DB_RELEASE, key_sync==1 held until cnt==DEBOUNCE_CYCLES-1 SHALL move the FSM to IDLE and clear long_done.
REQ-021 key_level SHALL be 1 in HELD and DB_RELEASE and 0 otherwise, registered.
REQ-022 mode SHALL increment modulo 4 (3 wraps to 0) in the cycle key_press is asserted.
REQ-023 mode SHALL be set to 0 in the cycle key_long is asserted; key_press and key_long SHALL never be high in the same cycle.
REQ-024 Latency: with key_n low and stable, key_press SHALL be high in the cycle after DEBOUNCE_CYCLES+3 rising edges, counting the first edge that samples key_n low as edge 1.
REQ-025 key_long SHALL rise exactly LONG_CYCLES cycles after key_press rises.

Reset
REQ-026 On rst=1 at a clock edge, the following SHALL apply regardless of FSM state: state=IDLE, cnt=0, long_done=0, synchronizer flops=1, key_press=0, key_long=0, key_level=0, mode=0.
REQ-027 A reset asserted mid-press SHALL produce no pulse; after release of rst, a still-held key SHALL be re-debounced from IDLE.

Structure
REQ-028 State encodings and the mode width constant (MODE_W=2) SHALL reside in shared package led_pkg, also used by the downstream LED FSM.
REQ-029 The synchronizer SHALL be a separate sub-module sync_2ff, reusable by other key inputs.

Verification (DEBOUNCE_CYCLES=5, LONG_CYCLES=20, 20 ns clock)
REQ-030 Reset: rst high for 3 cycles -> all outputs 0 and mode=0 on the first cycle after reset.
REQ-031 Clean press: key_n low for 12 cycles then high -> key_press high exactly one cycle, 8 edges after key_n falls; mode goes 0->1; key_long stays 0.
REQ-032 Bounce: key_n low 3 cycles, high 2, low 3, high -> no key_press, mode unchanged, key_level stays 0.
REQ-033 Four clean presses -> mode sequence 1,2,3,0.
REQ-034 Long hold: key_n low 40 cycles -> key_press, then key_long exactly 20 cycles later; mode goes 1 then 0; key_long fires once only.
REQ-035 Reset mid-hold: rst pulsed 1 cycle while in HELD with key still low -> outputs cleared; a fresh key_press follows 8 edges later.
